// File: rtl/system_ocm_pkg.sv
// Shared definitions for the multi-port shared on-chip memory.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package system_ocm_pkg;

  localparam int MAX_PORTS = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of a port index; never zero so single-port builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int TAG_PORT_W = clog2(MAX_PORTS);

  // Read tag carried alongside the RAM read pipeline.
  typedef struct packed {
    logic                  valid;
    logic [TAG_PORT_W-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/system_ocm_ram.sv
// Single-port byte-enabled RAM; out-of-range writes ignored, reads return 0.
// Latency: 1 cycle (RAM register), 2 with the optional output register.
// Backpressure: none; whole array and output pipe freeze while i_clken=0.
// Ports: clk; i_clken stall; i_wr_en/i_rd_en one access per cycle;
//        i_addr word address; i_be byte lanes; i_wdata; o_rdata.
module system_ocm_ram
  import system_ocm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int DEPTH        = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    i_clken,
  input  logic                    i_wr_en,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = idx_w(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q1;
  logic                  w_in_range;
  logic [IW-1:0]         w_idx;

  assign w_in_range = (32'(i_addr) < 32'(DEPTH));
  assign w_idx      = IW'(i_addr);

  always_ff @(posedge clk) begin
    if (i_clken) begin
      if (i_wr_en && w_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (i_be[b]) r_mem[w_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
      if (i_rd_en) r_q1 <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q2;
      always_ff @(posedge clk) begin
        if (i_clken) r_q2 <= r_q1;
      end
      assign o_rdata = r_q2;
    end else begin : g_noreg
      assign o_rdata = r_q1;
    end
  endgenerate

endmodule

// File: rtl/system_shared_ocm.sv
// N-port Avalon-MM shared memory: round-robin arbiter in front of one RAM.
// Latency: READ_LATENCY clocks (counting clken=1 edges) from grant to readdatavalid.
// Backpressure: combinational waitrequest to every requester not granted.
// Ports: clk, reset_n (sync, active low), clken (global stall);
//        s_* Avalon slave buses, port i in slice i of each vector.
module system_shared_ocm
  import system_ocm_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int DEPTH        = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clken,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_address,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_byteenable,
  input  logic [NUM_PORTS-1:0]              s_read,
  input  logic [NUM_PORTS-1:0]              s_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_writedata,
  output logic [NUM_PORTS-1:0]              s_waitrequest,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   s_readdata,
  output logic [NUM_PORTS-1:0]              s_readdatavalid
);

  localparam int PW = idx_w(NUM_PORTS);
  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_grant;
  logic                  w_any;
  logic [PW-1:0]         w_gnt_idx;
  logic [PW-1:0]         r_rr;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_is_wr;
  logic                  w_ram_wr;
  logic                  w_ram_rd;
  logic [DATA_WIDTH-1:0] w_ram_q;

  rd_tag_t               r_tag [READ_LATENCY];
  rd_tag_t               w_tag_out;
  logic [NUM_PORTS-1:0]  w_rdv;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_hold;

  // read+write together counts as a write
  assign w_req = s_read | s_write;

  // Search upward from the rr pointer, wrapping; first requester wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    if (clken) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!w_any && w_req[(int'(r_rr) + k) % NUM_PORTS]) begin
          w_any     = 1'b1;
          w_gnt_idx = PW'((int'(r_rr) + k) % NUM_PORTS);
        end
      end
    end
    if (w_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign s_waitrequest = w_req & ~w_grant;

  // Route the granted port's request to the RAM.
  always_comb begin
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    w_is_wr = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_addr  = s_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_be    = s_byteenable[i*NB +: NB];
        w_wdata = s_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        w_is_wr = s_write[i];
      end
    end
  end

  assign w_ram_wr = w_any &  w_is_wr;
  assign w_ram_rd = w_any & ~w_is_wr;

  system_ocm_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .clk    (clk),
    .i_clken(clken),
    .i_wr_en(w_ram_wr),
    .i_rd_en(w_ram_rd),
    .i_addr (w_addr),
    .i_be   (w_be),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_q)
  );

  // No grant while clken=0, so the pointer naturally holds then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr <= '0;
    end else if (w_any) begin
      r_rr <= (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);
    end
  end

  // Tag pipeline runs in lockstep with the RAM read path, including stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < READ_LATENCY; k++) r_tag[k] <= '0;
    end else if (clken) begin
      r_tag[0].valid <= w_ram_rd;
      r_tag[0].port  <= TAG_PORT_W'(w_gnt_idx);
      for (int k = 1; k < READ_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tag_out = r_tag[READ_LATENCY-1];

  always_comb begin
    w_rdv = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_rdv[i] = clken & w_tag_out.valid & (w_tag_out.port == TAG_PORT_W'(i));
    end
  end

  assign s_readdatavalid = w_rdv;

  // Each port's slice shows RAM data on its valid cycle, else its last result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_rdv[i]) r_hold[i*DATA_WIDTH +: DATA_WIDTH] <= w_ram_q;
      end
    end
  end

  always_comb begin
    s_readdata = r_hold;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_rdv[i]) s_readdata[i*DATA_WIDTH +: DATA_WIDTH] = w_ram_q;
    end
  end

endmodule

// File: tb/tb_system_shared_ocm.sv
// Bench for system_shared_ocm: table of single-port accesses plus contention,
// latency-2 streaming, clken stall and reset-during-read sequences.
// Two instances: A (LAT=1, DEPTH=1000) and B (LAT=2, DEPTH=2048).
module tb_system_shared_ocm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_clken;
  logic [21:0] a_addr;
  logic [7:0]  a_be;
  logic [1:0]  a_rd, a_wr, a_wait, a_rdv;
  logic [63:0] a_wd, a_rdata;

  logic        b_rstn, b_clken;
  logic [21:0] b_addr;
  logic [7:0]  b_be;
  logic [1:0]  b_rd, b_wr, b_wait, b_rdv;
  logic [63:0] b_wd, b_rdata;

  system_shared_ocm #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(11), .DEPTH(1000), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset_n(a_rstn), .clken(a_clken),
    .s_address(a_addr), .s_byteenable(a_be), .s_read(a_rd), .s_write(a_wr),
    .s_writedata(a_wd), .s_waitrequest(a_wait), .s_readdata(a_rdata),
    .s_readdatavalid(a_rdv)
  );

  system_shared_ocm #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(11), .DEPTH(2048), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset_n(b_rstn), .clken(b_clken),
    .s_address(b_addr), .s_byteenable(b_be), .s_read(b_rd), .s_write(b_wr),
    .s_writedata(b_wd), .s_waitrequest(b_wait), .s_readdata(b_rdata),
    .s_readdatavalid(b_rdv)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input int p, input logic rd, input logic wr, input logic [10:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    a_rd[p] = rd;
    a_wr[p] = wr;
    a_addr[p*11 +: 11] = addr;
    a_be[p*4 +: 4] = be;
    a_wd[p*32 +: 32] = wd;
  endtask

  task automatic b_set(input int p, input logic rd, input logic wr, input logic [10:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    b_rd[p] = rd;
    b_wr[p] = wr;
    b_addr[p*11 +: 11] = addr;
    b_be[p*4 +: 4] = be;
    b_wd[p*32 +: 32] = wd;
  endtask

  typedef struct {
    logic        wr;
    int          port;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s;

    tbl[0]  = '{1'b1, 0, 11'd5,    4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 0, 11'd5,    4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 0, 11'd7,    4'hF, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b1, 0, 11'd7,    4'h5, 32'hAABBCCDD, 32'h0};
    tbl[4]  = '{1'b0, 0, 11'd7,    4'hF, 32'h0,        32'h11BB33DD};
    tbl[5]  = '{1'b1, 1, 11'd476,  4'hF, 32'hCAFEF00D, 32'h0};
    tbl[6]  = '{1'b1, 1, 11'd1500, 4'hF, 32'h12345678, 32'h0};
    tbl[7]  = '{1'b0, 1, 11'd1500, 4'hF, 32'h0,        32'h00000000};
    tbl[8]  = '{1'b0, 0, 11'd476,  4'hF, 32'h0,        32'hCAFEF00D};
    tbl[9]  = '{1'b1, 1, 11'd5,    4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[10] = '{1'b0, 1, 11'd5,    4'hF, 32'h0,        32'hDEADBEEF};
    tbl[11] = '{1'b1, 0, 11'd999,  4'hF, 32'h0BADC0DE, 32'h0};
    tbl[12] = '{1'b0, 0, 11'd999,  4'hF, 32'h0,        32'h0BADC0DE};
    tbl[13] = '{1'b0, 0, 11'd1000, 4'hF, 32'h0,        32'h00000000};

    a_rstn = 1'b0; a_clken = 1'b1; a_addr = '0; a_be = '0; a_rd = '0; a_wr = '0; a_wd = '0;
    b_rstn = 1'b0; b_clken = 1'b1; b_addr = '0; b_be = '0; b_rd = '0; b_wr = '0; b_wd = '0;
    tick;
    tick;
    chk("a_rst_rdv",   64'(a_rdv),   64'h0);
    chk("a_rst_rdata", a_rdata,      64'h0);
    chk("a_rst_wait",  64'(a_wait),  64'h0);
    chk("b_rst_rdv",   64'(b_rdv),   64'h0);
    chk("b_rst_rdata", b_rdata,      64'h0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;

    // Single-requester accesses on instance A.
    for (int i = 0; i < NV; i++) begin
      a_set(tbl[i].port, ~tbl[i].wr, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd);
      #1;
      chk($sformatf("tbl%0d_wait", i), 64'(a_wait), 64'h0);
      tick;
      a_rd = '0;
      a_wr = '0;
      if (!tbl[i].wr) begin
        s = a_rdata[tbl[i].port*32 +: 32];
        chk($sformatf("tbl%0d_rdv", i), 64'(a_rdv), 64'(2'b01 << tbl[i].port));
        chk($sformatf("tbl%0d_data", i), 64'(s), 64'(tbl[i].exp));
      end else begin
        chk($sformatf("tbl%0d_rdv", i), 64'(a_rdv), 64'h0);
      end
    end

    // Contention from reset: grants alternate 0,1,0,1; idle slices hold.
    a_rstn = 1'b0;
    tick;
    a_rstn = 1'b1;
    a_set(0, 1'b1, 1'b0, 11'd5,   4'hF, 32'h0);
    a_set(1, 1'b1, 1'b0, 11'd476, 4'hF, 32'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("cont%0d_wait", c), 64'(a_wait), (c % 2 == 0) ? 64'h2 : 64'h1);
      tick;
      chk($sformatf("cont%0d_rdv", c), 64'(a_rdv), (c % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("cont%0d_data", c), a_rdata,
          (c == 0) ? 64'h00000000_DEADBEEF : 64'hCAFEF00D_DEADBEEF);
    end
    a_rd = '0;
    a_wr = '0;

    // Instance B: load words 0..3 with 0..3 via port 1.
    for (int k = 0; k < 4; k++) begin
      b_set(1, 1'b0, 1'b1, 11'(k), 4'hF, 32'(k));
      tick;
    end
    b_wr = '0;

    // Latency 2, back-to-back reads: four consecutive valids starting 2 after grant.
    for (int c = 0; c < 6; c++) begin
      if (c < 4) b_set(1, 1'b1, 1'b0, 11'(c), 4'hF, 32'h0);
      else b_rd = '0;
      #1;
      chk($sformatf("lat2_%0d_wait", c), 64'(b_wait), 64'h0);
      tick;
      if (c >= 1 && c <= 4) begin
        chk($sformatf("lat2_%0d_rdv", c), 64'(b_rdv), 64'h2);
        chk($sformatf("lat2_%0d_data", c), 64'(b_rdata[63:32]), 64'(c - 1));
      end else begin
        chk($sformatf("lat2_%0d_rdv", c), 64'(b_rdv), 64'h0);
      end
    end

    // clken stall for 3 cycles after a read grant.
    b_set(1, 1'b1, 1'b0, 11'd2, 4'hF, 32'h0);
    #1;
    chk("stall_grant_wait", 64'(b_wait), 64'h0);
    tick;
    b_rd = '0;
    b_clken = 1'b0;
    b_set(0, 1'b1, 1'b0, 11'd0, 4'hF, 32'h0);
    for (int s_i = 0; s_i < 3; s_i++) begin
      #1;
      chk($sformatf("stall%0d_wait", s_i), 64'(b_wait), 64'h1);
      chk($sformatf("stall%0d_rdv", s_i), 64'(b_rdv), 64'h0);
      tick;
      chk($sformatf("stall%0d_rdv_post", s_i), 64'(b_rdv), 64'h0);
    end
    b_rd = '0;
    b_clken = 1'b1;
    #1;
    chk("stall_resume_pre_rdv", 64'(b_rdv), 64'h0);
    tick;
    chk("stall_resume_rdv", 64'(b_rdv), 64'h2);
    chk("stall_resume_data", 64'(b_rdata[63:32]), 64'h2);
    tick;
    chk("stall_after_rdv", 64'(b_rdv), 64'h0);

    // Reset the cycle after a read grant: the read never returns.
    b_set(1, 1'b1, 1'b0, 11'd1, 4'hF, 32'h0);
    tick;
    b_rd = '0;
    b_rstn = 1'b0;
    tick;
    chk("rstmid_rdv0", 64'(b_rdv), 64'h0);
    chk("rstmid_rdata", b_rdata, 64'h0);
    b_rstn = 1'b1;
    tick;
    chk("rstmid_rdv1", 64'(b_rdv), 64'h0);
    tick;
    chk("rstmid_rdv2", 64'(b_rdv), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
